// File: rtl/dbus_responder.sv
// Single-outstanding data-bus responder backed by a DEPTH x 64-bit memory.
// Accepts one request, answers LATENCY cycles later, then returns to IDLE.
module dbus_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [63:0] req_addr,
   input  logic [2:0]  req_size,
   input  logic [7:0]  req_strobe,
   input  logic [63:0] req_data,
   output logic        resp_addr_ok,
   output logic        resp_data_ok,
   output logic [63:0] resp_data,
   output logic        resp_err
);
   localparam int NUM_LANES = 8;
   localparam int IW        = $clog2(DEPTH);
   localparam int CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;

   typedef struct packed {
      logic [IW-1:0]           idx;
      logic [NUM_LANES-1:0]    strobe;
      logic [63:0]             data;
      logic                    err;
   } req_t;

   logic [0:0]  state;
   logic [CW-1:0] cnt;
   req_t        req_q;
   req_t        req_d;
   logic        misaligned;
   logic        illegal;
   logic [NUM_LANES-1:0][7:0] mem [DEPTH];

   // Address bits above the word index alias and are intentionally dropped.
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[63:IW+3];

   always_comb begin
      misaligned = 1'b0;
      illegal    = 1'b0;
      case (req_size)
         3'd0:    misaligned = 1'b0;
         3'd1:    misaligned = req_addr[0];
         3'd2:    misaligned = |req_addr[1:0];
         3'd3:    misaligned = |req_addr[2:0];
         default: illegal    = 1'b1;
      endcase
   end

   always_comb begin
      req_d.idx    = req_addr[IW+2:3];
      req_d.strobe = req_strobe;
      req_d.data   = req_data;
      req_d.err    = misaligned | illegal;
   end

   assign resp_addr_ok = reset & (state == IDLE) & req_valid;
   assign resp_data_ok = (state == WAIT) && (cnt == '0);
   assign resp_err     = resp_data_ok & req_q.err;
   assign resp_data    = (resp_data_ok && !req_q.err && req_q.strobe == '0)
                         ? mem[req_q.idx] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         req_q <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               state <= WAIT;
               cnt   <= CW'(LATENCY - 1);
               req_q <= req_d;
            end
            WAIT: if (cnt == '0) state <= IDLE;
                  else           cnt   <= cnt - 1'b1;
            default: state <= IDLE;
         endcase
      end
   end

   // Write commits on the edge that ends the data_ok cycle; errored requests never write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
      end else if (resp_data_ok && !req_q.err) begin
         for (int l = 0; l < NUM_LANES; l++)
            if (req_q.strobe[l]) mem[req_q.idx][l] <= req_q.data[l*8 +: 8];
      end
   end

endmodule

// File: tb/tb_dbus_responder.sv
// Randomized + directed bench for dbus_responder against a cycle-count based
// reference model (accept time, due time, flat memory array).
module tb_dbus_responder;
   localparam int DEPTH   = 256;
   localparam int LATENCY = 2;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic [63:0] req_addr;
   logic [2:0]  req_size;
   logic [7:0]  req_strobe;
   logic [63:0] req_data;
   logic        resp_addr_ok;
   logic        resp_data_ok;
   logic [63:0] resp_data;
   logic        resp_err;

   dbus_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_strobe   (req_strobe),
      .req_data     (req_data),
      .resp_addr_ok (resp_addr_ok),
      .resp_data_ok (resp_data_ok),
      .resp_data    (resp_data),
      .resp_err     (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [63:0] mmem [DEPTH];
   int          cyc;
   int          next_free;
   bit          pend;
   int          due;
   logic [63:0] p_addr, p_data;
   logic [2:0]  p_size;
   logic [7:0]  p_strb;
   logic [63:0] last_data;
   logic        last_err;
   int          ok_cnt;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic bit is_err(input logic [63:0] a, input logic [2:0] s);
      if (s > 3'd3) return 1'b1;
      return (a % (64'd1 << s)) != 64'd0;
   endfunction

   function automatic int word_of(input logic [63:0] a);
      return int'((a >> 3) % 64'(DEPTH));
   endfunction

   // One clock cycle: drive, check at negedge, advance model at posedge.
   task automatic step(input bit v, input logic [63:0] a, input logic [2:0] s,
                       input logic [7:0] st, input logic [63:0] d);
      bit          exp_acc, exp_dok, e_err;
      logic [63:0] e_data;
      int          w;
      req_valid = v; req_addr = a; req_size = s; req_strobe = st; req_data = d;
      @(negedge clk);
      exp_acc = v && (cyc >= next_free);
      exp_dok = pend && (cyc == due);
      e_err   = 1'b0;
      e_data  = '0;
      if (exp_dok) begin
         e_err = is_err(p_addr, p_size);
         if (!e_err && p_strb == 8'h00) e_data = mmem[word_of(p_addr)];
      end
      chk("addr_ok", 64'(resp_addr_ok), 64'(exp_acc));
      chk("data_ok", 64'(resp_data_ok), 64'(exp_dok));
      chk("resp_err", 64'(resp_err), 64'(e_err));
      chk("resp_data", resp_data, e_data);
      if (exp_dok) begin
         last_data = resp_data;
         last_err  = resp_err;
         ok_cnt++;
      end
      @(posedge clk);
      if (exp_dok) begin
         if (!e_err) begin
            w = word_of(p_addr);
            for (int b = 0; b < 8; b++)
               if (p_strb[b]) mmem[w][b*8 +: 8] = p_data[b*8 +: 8];
         end
         pend = 1'b0;
      end
      if (exp_acc) begin
         pend = 1'b1; due = cyc + LATENCY; next_free = cyc + LATENCY + 1;
         p_addr = a; p_size = s; p_strb = st; p_data = d;
      end
      cyc++;
      #1;
   endtask

   task automatic drain();
      while (pend || cyc < next_free) step(1'b0, '0, '0, '0, '0);
   endtask

   task automatic xact(input logic [63:0] a, input logic [2:0] s,
                       input logic [7:0] st, input logic [63:0] d);
      step(1'b1, a, s, st, d);
      drain();
   endtask

   task automatic pulse_reset(input int n);
      reset = 1'b0; req_valid = 1'b1;
      pend = 1'b0;
      for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
      repeat (n) begin
         @(negedge clk);
         chk("rst_addr_ok", 64'(resp_addr_ok), 64'd0);
         chk("rst_data_ok", 64'(resp_data_ok), 64'd0);
         chk("rst_data", resp_data, 64'd0);
         chk("rst_err", 64'(resp_err), 64'd0);
         @(posedge clk);
         cyc++;
         #1;
      end
      reset = 1'b1; req_valid = 1'b0;
      next_free = cyc;
   endtask

   initial begin
      int start_ok;
      logic [63:0] a;
      logic [2:0]  s;
      int          r;
      reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0;
      req_strobe = '0; req_data = '0;
      cyc = 0; next_free = 0; pend = 0; due = 0; ok_cnt = 0;
      pulse_reset(2);

      // Write then read
      xact(64'h10, 3'd3, 8'hFF, 64'h1122334455667788);
      chk("wr_err", 64'(last_err), 64'd0);
      chk("wr_data", last_data, 64'd0);
      xact(64'h10, 3'd3, 8'h00, '0);
      chk("rd_full", last_data, 64'h1122334455667788);
      // Partial write
      xact(64'h10, 3'd0, 8'h04, 64'h0000000000AB0000);
      xact(64'h10, 3'd3, 8'h00, '0);
      chk("rd_partial", last_data, 64'h1122334455AB7788);
      // Misaligned write
      xact(64'h12, 3'd2, 8'hF0, 64'hDEADBEEF00000000);
      chk("misal_err", 64'(last_err), 64'd1);
      xact(64'h10, 3'd3, 8'h00, '0);
      chk("misal_nowr", last_data, 64'h1122334455AB7788);
      // Illegal size
      xact(64'h10, 3'd5, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("illegal_err", 64'(last_err), 64'd1);

      // Back-to-back with valid held: accepts at T0 and T0+3
      start_ok = ok_cnt;
      repeat (6) step(1'b1, 64'h10, 3'd3, 8'h00, '0);
      drain();
      chk("b2b_count", 64'(ok_cnt - start_ok), 64'd2);
      // Valid dropped right after accept
      step(1'b1, 64'h10, 3'd3, 8'h00, '0);
      step(1'b0, 64'h18, 3'd3, 8'hFF, '1);
      step(1'b0, 64'h18, 3'd3, 8'hFF, '1);
      chk("drop_valid", last_data, 64'h1122334455AB7788);
      drain();

      // Reset mid-transaction
      step(1'b1, 64'h08, 3'd3, 8'hFF, 64'hCAFEF00DCAFEF00D);
      pulse_reset(2);
      xact(64'h08, 3'd3, 8'h00, '0);
      chk("rst_abort", last_data, 64'd0);
      xact(64'h10, 3'd3, 8'h00, '0);
      chk("rst_clear", last_data, 64'd0);

      // Aliasing modulo DEPTH*8
      xact(64'h800, 3'd3, 8'hFF, 64'h0123456789ABCDEF);
      xact(64'h000, 3'd3, 8'h00, '0);
      chk("alias", last_data, 64'h0123456789ABCDEF);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         a = 64'($urandom_range(0, 31)) << 3 | 64'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) a = a | ({32'($urandom), 32'($urandom)} << 11);
         r = $urandom_range(0, 9);
         s = (r > 7) ? 3'd3 : 3'(r);
         if ($urandom_range(0, 79) == 0) pulse_reset($urandom_range(1, 2));
         else step($urandom_range(0, 3) != 0, a, s,
                   ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom),
                   {32'($urandom), 32'($urandom)});
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dbus_responder.md
DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 64-bit memory words (power of two, at least 2).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the number of cycles from accept to data_ok (at least 1).
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset (0 = asserted).
REQ-005 SHALL have port req_valid  input  1  the core is presenting a data request.
REQ-006 SHALL have port req_addr  input  64  byte address.
REQ-007 SHALL have port req_size  input  3  access size log2 bytes: 0=1B, 1=2B, 2=4B, 3=8B; values 4-7 illegal.
REQ-008 SHALL have port req_strobe  input  8  byte-write enables; all zero = read.
REQ-009 SHALL have port req_data  input  64  write data, already lane-aligned.
REQ-010 SHALL have port resp_addr_ok  output  1  request accepted this cycle.
REQ-011 SHALL have port resp_data_ok  output  1  response valid this cycle; transaction complete.
REQ-012 SHALL have port resp_data  output  64  read data.
REQ-013 SHALL have port resp_err  output  1  misaligned or illegal-size request; qualified by resp_data_ok.

Function
REQ-014 SHALL implement FSM states IDLE and WAIT.
REQ-015 In IDLE, resp_addr_ok SHALL equal req_valid, combinationally; resp_addr_ok SHALL be 0 in WAIT.
REQ-016 On accept, the block SHALL latch addr, size, strobe and data, load the counter with LATENCY-1 and move to WAIT.
REQ-017 In WAIT, the counter SHALL decrement each cycle; resp_data_ok SHALL be 1 for exactly one cycle, when the counter is 0.
REQ-018 The data_ok cycle SHALL be the accept cycle plus LATENCY.
REQ-019 After the data_ok cycle, the FSM SHALL return to IDLE; no accept in the data_ok cycle; minimum issue interval = LATENCY+1 cycles.
REQ-020 Word index SHALL be latched addr[3+log2(DEPTH)-1:3]; higher address bits are ignored, so addresses alias modulo DEPTH*8.
REQ-021 A request SHALL be misaligned when addr mod 2^size != 0.
REQ-022 A request SHALL be illegal when size > 3.
REQ-023 Misaligned and illegal requests SHALL raise resp_err, perform no write, and return resp_data = 0.
REQ-024 A read SHALL return the full indexed word on resp_data in the data_ok cycle; the core extracts the lanes.
REQ-025 A write SHALL update only the strobed bytes, committed at the clock edge ending the data_ok cycle.
REQ-026 A write SHALL return resp_data = 0.
REQ-027 Changes to req_valid or the request fields after accept SHALL not affect the in-flight transaction, including req_valid dropping to 0.
REQ-028 resp_data and resp_err SHALL be 0 whenever resp_data_ok = 0.

Reset
REQ-029 Reset asserted SHALL immediately force: FSM to IDLE, counter to 0, all memory words to 0, and resp_data_ok, resp_data, resp_err to 0.
REQ-030 Reset mid-transaction SHALL abort it: no write, no data_ok.
REQ-031 While reset is asserted, resp_addr_ok SHALL be 0.
REQ-032 The first accept SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-033 Write then read, LATENCY=2:
- write addr 0x10, size 3, strobe 0xFF, data 0x1122334455667788 -> addr_ok at T0, data_ok at T0+2, err 0.
- read 0x10 -> data 0x1122334455667788.
REQ-034 Partial write:
- after REQ-033, write 0x10, size 0, strobe 0x04, data 0x0000000000AB0000.
- read 0x10 -> 0x1122334455AB7788.
REQ-035 Misaligned write:
- write 0x12, size 2, strobe 0xF0 -> data_ok with err 1.
- read 0x10 -> value unchanged.
REQ-036 Back-to-back requests with req_valid held high:
- addr_ok at T0 and T0+3 only.
- data_ok at T0+2 and T0+5.
- req_valid dropped at T0+1 -> data_ok still at T0+2.
REQ-037 Reset mid-operation:
- write 0x08 accepted, reset asserted at T0+1 -> no data_ok.
- after release, read 0x08 -> 0.
REQ-038 Aliasing, DEPTH=256:
- write 0x800 -> read 0x000 returns the written data.
